// File: rtl/elevator_scheduler.sv
// ----------------------------------------------------------------------------
// elevator_scheduler
//
// Floor-request scheduler for a 3-floor car. It latches hall/car calls and
// picks a direction using a sweep policy: the car keeps its current direction
// while calls remain ahead of it. It stops at called floors and times the door.
// It also gates the move-frequency generator through move_handler, and counts
// each rising edge of move_clk as one floor travelled.
//
// Optional feature macro: SOS_CLEAR_REQ_EN
//   defined   : entering SOS drops every latched request.
//   undefined : requests survive SOS and are serviced after release.
//
// Parameters
//   door_time   : clk cycles the door stays open (1 .. 2^26-1)
//   start_floor : floor loaded on reset (1 .. 3)
//
// Ports
//   clk                   : system clock
//   button_reset          : synchronous active-high reset
//   call[2:0]             : floor call pulses, bit0 = floor 1
//   move_clk              : step strobe from the move-frequency generator
//   sos_mode              : emergency stop (level)
//   weight_limit_exceeded : overload (level)
//   led1..led3            : one-hot current floor
//   move_handler          : car authorised to move
//   dir_up                : current / last travel direction is up
//   door_open             : door open indicator
//   pending[2:0]          : latched requests, same bit order as call
//   state_o[2:0]          : FSM state encoding
// ----------------------------------------------------------------------------
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE  0  | stationary, door closed, choosing the next target
// MOVE_UP 1| travelling up, one floor per move_clk rising edge
// MOVE_DN 2| travelling down, one floor per move_clk rising edge
// DOOR  3  | stopped at a served floor, door timer running
// SOS   4  | emergency hold: no motion, door closed, calls ignored
// ----------------------------------------------------------------------------
module elevator_scheduler #(
    parameter int unsigned door_time   = 50,
    parameter int unsigned start_floor = 1
) (
    input  logic       clk,
    input  logic       button_reset,
    input  logic [2:0] call,
    input  logic       move_clk,
    input  logic       sos_mode,
    input  logic       weight_limit_exceeded,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       move_handler,
    output logic       dir_up,
    output logic       door_open,
    output logic [2:0] pending,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MOVE_UP = 3'd1,
        ST_MOVE_DN = 3'd2,
        ST_DOOR    = 3'd3,
        ST_SOS     = 3'd4
    } state_t;

    localparam logic [25:0] door_load = 26'(door_time);
    localparam logic [2:0]  start_led = (start_floor == 3) ? 3'b100 :
                                        (start_floor == 2) ? 3'b010 : 3'b001;

    state_t      state;
    logic [2:0]  pos;          // one-hot car position, bit0 = floor 1
    logic [25:0] door_timer;
    logic        move_clk_q;

    logic        step;
    logic [2:0]  above_mask;
    logic [2:0]  below_mask;
    logic [2:0]  up_led;
    logic [2:0]  dn_led;
    logic [2:0]  call_latch;
    logic [2:0]  pending_in;

    assign step = move_clk & ~move_clk_q;

    // Floor masks derived directly from the one-hot position.
    assign above_mask = {pos[0] | pos[1], pos[0], 1'b0};
    assign below_mask = {1'b0, pos[2], pos[1] | pos[2]};
    assign up_led     = {pos[1], pos[0], 1'b0};
    assign dn_led     = {1'b0, pos[2], pos[1]};

    // Calls are ignored in SOS. In DOOR, a call for the floor the car is
    // already standing at only holds the door, so it is not latched.
    always_comb begin
        call_latch = call;
        if (state == ST_SOS) begin
            call_latch = 3'b000;
        end else if (state == ST_DOOR) begin
            call_latch = call & ~pos;
        end
    end

    assign pending_in = pending | call_latch;

    always_ff @(posedge clk) begin
        if (button_reset) begin
            state        <= ST_IDLE;
            pos          <= start_led;
            pending      <= 3'b000;
            move_handler <= 1'b0;
            door_open    <= 1'b0;
            dir_up       <= 1'b1;
            door_timer   <= '0;
            move_clk_q   <= 1'b0;
        end else begin
            move_clk_q <= move_clk;
            pending    <= pending_in;

            if (sos_mode) begin
                state        <= ST_SOS;
                move_handler <= 1'b0;
                door_open    <= 1'b0;
                door_timer   <= '0;
`ifdef SOS_CLEAR_REQ_EN
                pending      <= 3'b000;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        // Overload keeps the car parked; requests stay latched.
                        if (!weight_limit_exceeded) begin
                            if (|(pending & pos)) begin
                                state      <= ST_DOOR;
                                door_open  <= 1'b1;
                                door_timer <= door_load;
                                pending    <= pending_in & ~pos;
                            end else if (|(pending & above_mask) &&
                                         (dir_up || !(|(pending & below_mask)))) begin
                                state        <= ST_MOVE_UP;
                                move_handler <= 1'b1;
                                dir_up       <= 1'b1;
                            end else if (|(pending & below_mask)) begin
                                state        <= ST_MOVE_DN;
                                move_handler <= 1'b1;
                                dir_up       <= 1'b0;
                            end
                        end
                    end

                    ST_MOVE_UP: begin
                        if (step) begin
                            if (pos[2]) begin
                                // Already at the top: position saturates.
                                state        <= ST_IDLE;
                                move_handler <= 1'b0;
                            end else begin
                                pos <= up_led;
                                // A call arriving with the step still stops here.
                                if (|(pending_in & up_led)) begin
                                    state        <= ST_DOOR;
                                    move_handler <= 1'b0;
                                    door_open    <= 1'b1;
                                    door_timer   <= door_load;
                                    pending      <= pending_in & ~up_led;
                                end else if (!(|(pending_in & above_mask & ~up_led))) begin
                                    state        <= ST_IDLE;
                                    move_handler <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_MOVE_DN: begin
                        if (step) begin
                            if (pos[0]) begin
                                // Already at the bottom: position saturates.
                                state        <= ST_IDLE;
                                move_handler <= 1'b0;
                            end else begin
                                pos <= dn_led;
                                if (|(pending_in & dn_led)) begin
                                    state        <= ST_DOOR;
                                    move_handler <= 1'b0;
                                    door_open    <= 1'b1;
                                    door_timer   <= door_load;
                                    pending      <= pending_in & ~dn_led;
                                end else if (!(|(pending_in & below_mask & ~dn_led))) begin
                                    state        <= ST_IDLE;
                                    move_handler <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_DOOR: begin
                        // Overload or a same-floor call holds the door open.
                        if (weight_limit_exceeded || |(call & pos)) begin
                            door_timer <= door_load;
                        end else if (door_timer == 26'd1) begin
                            state      <= ST_IDLE;
                            door_open  <= 1'b0;
                            door_timer <= '0;
                        end else begin
                            door_timer <= door_timer - 26'd1;
                        end
                    end

                    ST_SOS: begin
                        // sos_mode is low here, so the hold is released.
                        state <= ST_IDLE;
                    end

                    default: begin
                        state        <= ST_IDLE;
                        move_handler <= 1'b0;
                        door_open    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign led1    = pos[0];
    assign led2    = pos[1];
    assign led3    = pos[2];
    assign state_o = state;

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Floor-request scheduler for the 3-floor car. It sequences the move-frequency generator: asserts move_handler to run it, and consumes its move_clk rising edges as single floor steps.
- Latches hall/car calls, picks a direction (sweep-style: keep the current direction while calls remain ahead), stops at called floors and times the door.
- Drives the one-hot floor LEDs (led1..led3) that the move-frequency generator also samples.

Parameters:
- door_time, 50, clk cycles the door stays open after arrival (counter width 26 bits; values 1..2^26-1).
- start_floor, 1, floor loaded into the car position on reset (1..3).

Ports:
- clk  input  1  system clock
- button_reset  input  1  synchronous active-high reset, sampled on posedge clk
- call  input  3  floor call buttons, bit0 = floor1; a 1-cycle pulse latches a request
- move_clk  input  1  step signal from the move-frequency generator; each 0->1 transition = one floor travelled
- sos_mode  input  1  emergency stop, level
- weight_limit_exceeded  input  1  overload, level
- led1, led2, led3  output  1 each  one-hot current floor
- move_handler  output  1  1 = car authorised to move (generator counts)
- dir_up  output  1  1 = current/last direction up
- door_open  output  1  door open indicator
- pending  output  3  latched requests, same bit order as call
- state_o  output  3  FSM state encoding, for debug

Behaviour:
- Reset (synchronous, button_reset=1 at posedge clk): state=IDLE, floor=start_floor, led one-hot of start_floor, pending=0, move_handler=0, door_open=0, dir_up=1, door timer=0, move_clk history register=0.
- Step detect: step = move_clk & ~move_clk_q, where move_clk_q is move_clk registered each cycle. step is used only in MOVE_UP/MOVE_DN.
- Request latch: pending[i] is set on call[i]=1 every cycle, in any state except SOS. pending[i] for the current floor is cleared on entry to DOOR.
- IDLE (state 0):
  - pending at the current floor -> DOOR next cycle.
  - Else any pending above: if dir_up=1 or there is no pending below -> MOVE_UP, dir_up=1.
  - Else any pending below -> MOVE_DN, dir_up=0.
  - Blocked while weight_limit_exceeded=1: the FSM stays in IDLE and pending is kept.
- MOVE_UP (1) / MOVE_DN (2):
  - move_handler=1.
  - On step: floor moves +1/-1 and the LEDs update in the same cycle.
  - If the new floor is pending -> DOOR. Else if no pending remains ahead -> IDLE.
  - Floor saturates at 1 and 3: a step at a boundary does not change the floor, and the FSM goes to IDLE.
- DOOR (3):
  - move_handler=0, door_open=1, timer loaded to door_time on entry and decremented each cycle.
  - At timer==1 -> IDLE (door_open low the next cycle).
  - weight_limit_exceeded=1 reloads the timer to door_time, so the door stays open.
  - A call at the current floor while in DOOR reloads the timer and is not latched.
- SOS (4):
  - Entered from any state on sos_mode=1, with priority over all other transitions in that cycle.
  - move_handler=0, door_open=0, floor frozen, steps ignored, call ignored.
  - On sos_mode=0 -> IDLE and the scan restarts from the frozen floor and pending.
- Simultaneous events in the same cycle: step and a call at the new floor -> stop at that floor (DOOR). Reset has priority over sos_mode.
- move_handler and door_open are registered outputs that follow the state, i.e. they change 1 cycle after the transition condition.

Optional Feature:
- SOS_CLEAR_REQ_EN
  - Defined: entry to SOS clears pending to 0, and the car resumes IDLE with no calls.
  - Not defined: pending is retained through SOS and serviced after release.

Test Plan:
- Reset with start_floor=1 -> led1=1, led2=led3=0, pending=0, move_handler=0, state_o=0, door_open=0.
- Floor1 idle, pulse call=3'b100 -> MOVE_UP, move_handler=1; two move_clk rising edges -> led3=1, DOOR, door_open=1 for 50 cycles, pending=0, then IDLE.
- At floor3, calls 3'b001 then 3'b010 during the first MOVE_DN step -> stops at floor2 (DOOR), then continues to floor1; dir_up=0 throughout.
- In DOOR with weight_limit_exceeded held 100 cycles -> door_open stays 1; released -> closes 50 cycles later; pending call at floor1 is then served.
- sos_mode=1 mid-MOVE_UP between floor1 and floor2, with move_clk toggling -> floor stays 1, move_handler=0, state_o=4; release -> resumes and reaches the called floor. Run with and without SOS_CLEAR_REQ_EN and check pending (cleared vs retained).
- Pulse call at the current floor while IDLE -> door_open=1 two cycles later, no movement, move_handler never asserted.
